// File: rtl/proc_boot_pkg.sv
// Shared definitions for the processor boot controller: FSM state encoding
// and the default parameter values used by proc_boot_ctrl.
package proc_boot_pkg;

  localparam int unsigned DEF_DEPTH      = 256;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_RESET_HOLD = 4;
  localparam int unsigned DEF_TIMEOUT    = 1000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HOLD = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } boot_state_t;

endpackage

// File: rtl/boot_counter.sv
// Up-counter with synchronous clear and enable plus a terminal-count flag.
// Ports:
//   clk, resetn : clock and synchronous active-low reset
//   clr         : clear to zero (wins over en)
//   en          : advance by one
//   term        : terminal value compared against the count
//   cnt         : registered count value
//   tc_c        : combinational flag, cnt == term
module boot_counter
  import proc_boot_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         tc_c
);

  // Count register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc_c = (cnt == term);

endmodule

// File: rtl/proc_boot_ctrl.sv
// Boot controller: streams a program into instruction memory, holds the core
// in reset for a fixed number of cycles, lets it run until it halts or a
// cycle budget expires, then parks with status flags and counters held.
// Ports:
//   clk, resetn                      : clock, synchronous active-low reset
//   start                            : begin a load (from IDLE or DONE)
//   ld_valid/ld_ready/ld_data/ld_last: program stream handshake
//   imem_we/imem_addr/imem_wdata     : instruction-memory write port
//   core_resetn                      : active-low reset to the core
//   halt                             : core end-of-program indication
//   done/pass/timeout/overflow       : run status
//   load_cnt/cycle_cnt               : words loaded, cycles run
module proc_boot_ctrl
  import proc_boot_pkg::*;
#(
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned RESET_HOLD = DEF_RESET_HOLD,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
  localparam int unsigned AW        = $clog2(DEPTH),
  localparam int unsigned CW        = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              imem_we,
  output logic [AW-1:0]     imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              core_resetn,
  input  logic              halt,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic              overflow,
  output logic [AW:0]       load_cnt,
  output logic [CW-1:0]     cycle_cnt
);

  localparam int unsigned LW = AW + 1;
  localparam int unsigned HW = $clog2(RESET_HOLD + 1);

  boot_state_t state, state_d;

  // fin marks the final write cycle of a load, spent in LOAD with ld_ready low
  logic              fin, fin_d;
  logic              ld_ready_d;
  logic              imem_we_d;
  logic [AW-1:0]     imem_addr_d;
  logic [DATA_W-1:0] imem_wdata_d;
  logic              core_resetn_d;
  logic              done_d, pass_d, timeout_d, overflow_d;
  logic [LW-1:0]     load_cnt_d;

  logic              xfer_c;
  logic              at_top_c;
  logic              hold_clr_c, hold_en_c, hold_tc_c;
  logic [HW-1:0]     hold_cnt;
  logic              hold_cnt_unused_c;
  logic              run_clr_c, run_en_c, run_tc_c;

  assign xfer_c   = ld_valid && ld_ready;
  assign at_top_c = (load_cnt == LW'(DEPTH - 1));

  // Hold counter runs only while in HOLD and restarts from zero on each entry
  assign hold_clr_c = (state != ST_HOLD);
  assign hold_en_c  = (state == ST_HOLD);

  boot_counter #(.W(HW)) u_hold_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clr    (hold_clr_c),
    .en     (hold_en_c),
    .term   (HW'(RESET_HOLD - 1)),
    .cnt    (hold_cnt),
    .tc_c   (hold_tc_c)
  );

  // Only the terminal flag of the hold counter matters here
  assign hold_cnt_unused_c = ^hold_cnt;

  boot_counter #(.W(CW)) u_run_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clr    (run_clr_c),
    .en     (run_en_c),
    .term   (CW'(TIMEOUT - 1)),
    .cnt    (cycle_cnt),
    .tc_c   (run_tc_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d      = state;
    fin_d        = fin;
    ld_ready_d   = 1'b0;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr;
    imem_wdata_d = imem_wdata;
    pass_d       = pass;
    timeout_d    = timeout;
    overflow_d   = overflow;
    load_cnt_d   = load_cnt;
    run_clr_c    = 1'b0;
    run_en_c     = 1'b0;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_LOAD;
          fin_d      = 1'b0;
          ld_ready_d = 1'b1;
          load_cnt_d = '0;
          pass_d     = 1'b0;
          timeout_d  = 1'b0;
          overflow_d = 1'b0;
          run_clr_c  = 1'b1;
        end
      end

      ST_LOAD: begin
        if (fin) begin
          // Final write is on the bus this cycle; move on afterwards
          fin_d   = 1'b0;
          state_d = overflow ? ST_DONE : ST_HOLD;
        end else begin
          ld_ready_d = 1'b1;
          if (xfer_c) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = load_cnt[AW-1:0];
            imem_wdata_d = ld_data;
            load_cnt_d   = load_cnt + LW'(1);
            if (ld_last) begin
              fin_d      = 1'b1;
              ld_ready_d = 1'b0;
            end else if (at_top_c) begin
              // Last slot filled without ld_last: stop rather than wrap
              fin_d      = 1'b1;
              ld_ready_d = 1'b0;
              overflow_d = 1'b1;
            end
          end
        end
      end

      ST_HOLD: begin
        if (hold_tc_c) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // halt takes priority over an expiring cycle budget
        if (halt) begin
          state_d = ST_DONE;
          pass_d  = 1'b1;
        end else if (run_tc_c) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end else begin
          run_en_c = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    core_resetn_d = (state_d == ST_RUN);
    done_d        = (state_d == ST_DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      fin         <= 1'b0;
      ld_ready    <= 1'b0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      core_resetn <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      overflow    <= 1'b0;
      load_cnt    <= '0;
    end else begin
      state       <= state_d;
      fin         <= fin_d;
      ld_ready    <= ld_ready_d;
      imem_we     <= imem_we_d;
      imem_addr   <= imem_addr_d;
      imem_wdata  <= imem_wdata_d;
      core_resetn <= core_resetn_d;
      done        <= done_d;
      pass        <= pass_d;
      timeout     <= timeout_d;
      overflow    <= overflow_d;
      load_cnt    <= load_cnt_d;
    end
  end

endmodule
